// File: rtl/dummy_bitscan_unit.sv
// Iterates over the set bits of an accepted mask and emits one index per handshake, then pulses done with the count.
// Latency: first index valid the cycle after mask acceptance; done_o registered, one cycle after the final/aborting beat.
// Backpressure: idx_o/idx_last_o hold while idx_ready_i is low; mask_ready_o is low for the whole scan.
//
// Ports:
//   clk_i, rst_i                  clock (rising edge) and synchronous active-high reset
//   mask_i, mask_valid_i          mask offer; mask_ready_o high while idle
//   abort_i                       drop the remaining bits of the current scan (ignored while idle)
//   idx_o, idx_last_o             current set-bit index and final-bit flag
//   idx_valid_o, idx_ready_i      index stream handshake
//   done_o, cnt_o                 one-cycle completion pulse and number of indices handed off
module dummy_bitscan_unit #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    localparam int IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CntW = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic             mask_valid_i,
    output logic             mask_ready_o,
    input  logic             abort_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             idx_last_o,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic             done_o,
    output logic [CntW-1:0]  cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  cnt_out_q, cnt_out_d;
    logic             done_q, done_d;

    logic [IdxW-1:0]  idx_scan;
    logic [WIDTH-1:0] idx_onehot;
    logic [WIDTH-1:0] work_rest;
    logic             idx_hs;

    // Priority pick of the next set bit. The loop direction makes the last
    // matching assignment win: descending keeps the lowest set bit
    // (trailing-zero count), ascending keeps the highest (leading-one position).
    always_comb begin
        idx_scan = '0;
        if (MODE == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (work_q[i]) idx_scan = IdxW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (work_q[i]) idx_scan = IdxW'(i);
            end
        end
    end

    assign idx_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << idx_scan;
    assign work_rest  = work_q & ~idx_onehot;

    assign mask_ready_o = (state_q == IDLE);
    assign idx_valid_o  = (state_q == SCAN);
    // Work can be left nonzero by an abort, so the index is forced to zero
    // outside a scan to keep the idle outputs clean.
    assign idx_o        = (state_q == SCAN) ? idx_scan : '0;
    assign idx_last_o   = (state_q == SCAN) && (work_rest == '0);
    assign idx_hs       = idx_valid_o && idx_ready_i;
    assign done_o       = done_q;
    assign cnt_o        = cnt_out_q;

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        cnt_out_d = cnt_out_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mask_valid_i) begin
                    work_d = mask_i;
                    cnt_d  = '0;
                    if (mask_i == '0) begin
                        done_d    = 1'b1;
                        cnt_out_d = '0;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (idx_hs) begin
                    work_d = work_rest;
                    cnt_d  = cnt_q + CntW'(1);
                end
                // A beat completed in the abort cycle still counts.
                if ((idx_hs && idx_last_o) || abort_i) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    cnt_out_d = idx_hs ? (cnt_q + CntW'(1)) : cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work_q    <= '0;
            cnt_q     <= '0;
            cnt_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            cnt_out_q <= cnt_out_d;
            done_q    <= done_d;
        end
    end

endmodule
